// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - boot/load/run/step sequencer for the single-cycle core (optional SEQ_CYCLE_LIMIT_EN)
module cpu_seq_ctrl #(
    parameter int          IMEM_WORDS   = 64,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int          CLEAR_CYCLES = 4,
    parameter int          MAX_CYCLES   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic        boot_req,
    input  logic [31:0] instr,
    output logic        core_rst,
    output logic        core_en,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic [2:0]  state,
    output logic [31:0] instr_count,
    output logic        overflow
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_READY  = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_STEP   = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

    localparam int IDX_W = $clog2(IMEM_WORDS + 1);
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [IDX_W-1:0] word_idx;
    logic [CLR_W-1:0] clr_cnt;
    logic             is_halt_word;
    logic             load_xfer;
    logic             boot_take;
    logic             run_limit;

    assign state        = state_q;
    assign is_halt_word = (instr == HALT_WORD);
    assign load_xfer    = load_valid & load_ready;
    assign boot_take    = boot_req && (state_q != S_CLEAR);

`ifdef SEQ_CYCLE_LIMIT_EN
    localparam int RUN_W = $clog2(MAX_CYCLES + 1);
    logic [RUN_W-1:0] run_cnt;

    assign run_limit = (run_cnt == RUN_W'(MAX_CYCLES));

    // Counts enabled RUN cycles; any state other than RUN re-arms it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (state_q != S_RUN) begin
            run_cnt <= '0;
        end else if (core_en) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end
`else
    // No cycle limit in this build: the comparison folds to a constant 0.
    assign run_limit = (MAX_CYCLES < 0);
`endif

    // The halt word is gated in the same cycle so it is never executed.
    always_comb begin
        core_en = 1'b0;
        case (state_q)
            S_RUN:   core_en = !is_halt_word && !run_limit;
            S_STEP:  core_en = !is_halt_word;
            default: core_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (boot_take) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_CLEAR;
                S_CLEAR: begin
                    if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (load_xfer && load_last) state_d = S_READY;
                end
                S_READY: begin
                    if (halt_req)      state_d = S_HALTED;
                    else if (step_req) state_d = S_STEP;
                    else if (run_req)  state_d = S_RUN;
                end
                S_RUN: begin
                    if (halt_req || is_halt_word || run_limit) state_d = S_HALTED;
                end
                S_STEP: begin
                    if (halt_req || is_halt_word) state_d = S_HALTED;
                    else                          state_d = S_READY;
                end
                S_HALTED: state_d = S_HALTED;
                default:  state_d = S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_CLEAR;
            core_rst    <= 1'b1;
            load_ready  <= 1'b0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            instr_count <= '0;
            overflow    <= 1'b0;
            clr_cnt     <= '0;
            word_idx    <= '0;
        end else begin
            state_q    <= state_d;
            core_rst   <= (state_d == S_CLEAR) || (state_d == S_LOAD);
            load_ready <= (state_d == S_LOAD);
            imem_we    <= 1'b0;

            if (state_q == S_CLEAR) begin
                clr_cnt     <= clr_cnt + CLR_W'(1);
                word_idx    <= '0;
                instr_count <= '0;
            end else begin
                clr_cnt <= '0;
                if (core_en) instr_count <= instr_count + 32'd1;
            end

            // A boot request wins over a word offered in the same cycle.
            if (boot_take) begin
                overflow <= 1'b0;
            end else if (state_q == S_LOAD && load_xfer) begin
                if (word_idx == IDX_W'(IMEM_WORDS)) begin
                    overflow <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_wdata <= load_data;
                    imem_waddr <= 32'(word_idx) << 2;
                    word_idx   <= word_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Run/boot sequencer for the single-cycle processor core. Holds the core in reset and loads instruction memory word-by-word from a valid/ready stream, then runs, single-steps or halts the core by gating PC update and register/memory writes. Sits between the top level and the core: drives the core reset, the PC enable and the I_MEM write port.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops RUN.
CLEAR_CYCLES, 4, cycles the core reset is held after entering CLEAR (minimum 1).
MAX_CYCLES, 1024, run-cycle limit, used only with SEQ_CYCLE_LIMIT_EN.

Ports:
clk  in  1  processor clock
reset  in  1  synchronous reset, active-low
load_valid  in  1  load stream word valid
load_ready  out  1  sequencer accepts load word this cycle
load_data  in  32  instruction word to write
load_last  in  1  marks final word of the image
run_req  in  1  single-cycle pulse: free-run the core
step_req  in  1  single-cycle pulse: execute one instruction
halt_req  in  1  single-cycle pulse: stop the core
boot_req  in  1  single-cycle pulse: restart load sequence
instr  in  32  current instruction from I_MEM
core_rst  out  1  active-high reset to PC/REGFILE
core_en  out  1  PC update and RegWrite/MemWrite enable
imem_we  out  1  I_MEM write strobe
imem_waddr  out  32  I_MEM byte address (word index << 2)
imem_wdata  out  32  I_MEM write data
state  out  3  encoded state
instr_count  out  32  instructions retired since last CLEAR
overflow  out  1  sticky: load exceeded IMEM_WORDS

Behaviour:
- Reset (reset==0 at posedge): state=CLEAR, core_rst=1, core_en=0, load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, instr_count=0, overflow=0, clear counter=0.
- Encodings: IDLE=0, CLEAR=1, LOAD=2, READY=3, RUN=4, STEP=5, HALTED=6.
- CLEAR: core_rst=1 for exactly CLEAR_CYCLES cycles, then LOAD; word index and instr_count zeroed.
- LOAD: core_rst=1, load_ready=1. Transfer when load_valid&load_ready: imem_we=1 next cycle (registered, 1-cycle latency), imem_wdata=load_data, imem_waddr=index<<2, index+1. Transfer with load_last -> READY. Transfer when index==IMEM_WORDS: no write, overflow=1, word dropped; load_last still moves to READY.
- READY: core_rst=0, core_en=0 (PC stays at 0). run_req->RUN, step_req->STEP.
- RUN: core_en=1; each cycle with core_en=1 increments instr_count (wraps at 2^32). If instr==HALT_WORD, core_en=0 that cycle (halt word not executed, not counted) and -> HALTED. halt_req -> HALTED, core_en=0 from next cycle.
- STEP: core_en=1 for exactly one cycle (count+1) unless instr==HALT_WORD (then no enable, -> HALTED); otherwise -> READY.
- HALTED: core_en=0, PC/registers retained. run_req/step_req ignored; boot_req required.
- boot_req in any state except CLEAR: -> CLEAR next cycle; pending load word dropped; overflow cleared.
- Priority same cycle: reset > boot_req > halt_req > HALT_WORD detect > step_req > run_req. run_req/step_req in LOAD/CLEAR/RUN ignored.
- IDLE: unused; if entered, -> CLEAR next cycle.
- All outputs registered except core_en, combinational from state and instr (HALT_WORD gating).

Optional Feature:
SEQ_CYCLE_LIMIT_EN: when defined, RUN keeps a run-cycle counter zeroed on RUN entry; when it reaches MAX_CYCLES, core_en=0 and state -> HALTED, same as halt_req. When undefined, counter and comparison absent; RUN stops only on halt_req, HALT_WORD or boot_req.

Test Plan:
Reset low 2 cycles, release -> core_rst=1 for 4 cycles, state=2, load_ready=1, imem_we=0.
Load 3 words 0x20080005,0x21080001,0xFFFFFFFF (last on 3rd) -> imem_we pulses at waddr 0,4,8 with matching data; state=3, core_rst=0.
run_req in READY -> core_en=1 for exactly 2 cycles, instr_count=2, state=6 on HALT_WORD.
step_req twice from READY with non-halt code -> two single-cycle core_en pulses, instr_count=2, state back to 3 each time.
IMEM_WORDS=4, stream 6 words -> writes at 0..12 only, overflow=1, state=3 after load_last; boot_req -> overflow=0, state=1.
halt_req and step_req same cycle in READY -> state=6, no core_en pulse; with SEQ_CYCLE_LIMIT_EN, MAX_CYCLES=8, no halt word -> instr_count=8, state=6.
